// File: rtl/multi_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : multi_timer
// Description : CHANNELS independent down-counters on a shared tick, each
//               one-shot or auto-reload, with sticky per-channel interrupts.
//               Optional prescaler: define MULTI_TIMER_PRESCALER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_timer #(
    parameter int BITS     = 32,
    parameter int CHANNELS = 4,
    parameter int CH_BITS  = 2,
    parameter int PRE_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                nwr,
    input  logic [CH_BITS-1:0]  channel_sel,
    input  logic [1:0]          reg_sel,
    input  logic [BITS-1:0]     data_in,
    output logic [BITS-1:0]     data_out,
    output logic [CHANNELS-1:0] interrupt,
    input  logic [CHANNELS-1:0] interrupt_clear,
    output logic                irq_any
);

    localparam logic [1:0]      C_REG_VALUE    = 2'd0;
    localparam logic [1:0]      C_REG_CTRL     = 2'd1;
    localparam logic [1:0]      C_REG_PRESCALE = 2'd2;
    localparam logic [BITS-1:0] C_ONE          = {{(BITS-1){1'b0}}, 1'b1};

    logic                     w_sel_valid;
    logic                     w_wr;
    logic                     w_tick;
    logic [BITS-1:0]          w_prescale_rd;
    logic [CHANNELS*BITS-1:0] w_count_flat;
    logic [CHANNELS-1:0]      w_running;
    logic [CHANNELS-1:0]      w_periodic;

    generate
        if (CHANNELS < 1 || CHANNELS > 16 || (2**CH_BITS) < CHANNELS ||
            PRE_BITS < 1 || PRE_BITS > BITS || BITS < 2) begin : g_bad_params
            $error("multi_timer: inconsistent parameters");
        end
    endgenerate

    // channel_sel may be wider than the channel count; out-of-range selects are inert
    always_comb begin
        w_sel_valid = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (channel_sel == CH_BITS'(i)) begin
                w_sel_valid = 1'b1;
            end
        end
    end

    assign w_wr = !nwr && w_sel_valid;

`ifdef MULTI_TIMER_PRESCALER_EN
    localparam logic [PRE_BITS-1:0] C_PRE_ONE = {{(PRE_BITS-1){1'b0}}, 1'b1};

    logic [PRE_BITS-1:0] r_prescale;
    logic [PRE_BITS-1:0] r_pre_count;
    logic                w_wr_pre;

    assign w_wr_pre = w_wr && (reg_sel == C_REG_PRESCALE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prescale  <= '0;
            r_pre_count <= '0;
        end else if (w_wr_pre) begin
            r_prescale  <= data_in[PRE_BITS-1:0];
            r_pre_count <= '0;
        end else if (w_tick) begin
            r_pre_count <= '0;
        end else begin
            r_pre_count <= r_pre_count + C_PRE_ONE;
        end
    end

    assign w_tick        = (r_pre_count == r_prescale);
    assign w_prescale_rd = BITS'(r_prescale);
`else
    assign w_tick        = 1'b1;
    assign w_prescale_rd = '0;
`endif

    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
            logic [BITS-1:0] r_count;
            logic [BITS-1:0] r_reload;
            logic            r_running;
            logic            r_periodic;
            logic            r_irq;
            logic            w_hit;
            logic            w_wr_value;
            logic            w_wr_ctrl;
            logic            w_stop;
            logic            w_periodic_nxt;
            logic            w_active;
            logic            w_expire;

            assign w_hit          = w_wr && (channel_sel == CH_BITS'(g));
            assign w_wr_value     = w_hit && (reg_sel == C_REG_VALUE);
            assign w_wr_ctrl      = w_hit && (reg_sel == C_REG_CTRL);
            assign w_stop         = w_wr_ctrl && data_in[1];
            // A CTRL write takes effect before the same-cycle tick is applied
            assign w_periodic_nxt = w_wr_ctrl ? data_in[0] : r_periodic;
            assign w_active       = r_running && !w_stop && w_tick;
            assign w_expire       = w_active && (r_count == '0);

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_count    <= '0;
                    r_reload   <= '0;
                    r_running  <= 1'b0;
                    r_periodic <= 1'b0;
                    r_irq      <= 1'b0;
                end else if (w_wr_value) begin
                    r_count   <= data_in;
                    r_reload  <= data_in;
                    r_running <= 1'b1;
                    r_irq     <= 1'b0;
                end else begin
                    r_periodic <= w_periodic_nxt;
                    if (w_stop || (w_expire && !w_periodic_nxt)) begin
                        r_running <= 1'b0;
                    end
                    if (w_expire) begin
                        if (w_periodic_nxt) begin
                            r_count <= r_reload;
                        end
                    end else if (w_active) begin
                        r_count <= r_count - C_ONE;
                    end
                    if (w_expire) begin
                        r_irq <= 1'b1;
                    end else if (interrupt_clear[g]) begin
                        r_irq <= 1'b0;
                    end
                end
            end

            assign w_count_flat[g*BITS +: BITS] = r_count;
            assign w_running[g]                 = r_running;
            assign w_periodic[g]                = r_periodic;
            assign interrupt[g]                 = r_irq;
        end
    endgenerate

    always_comb begin
        data_out = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (channel_sel == CH_BITS'(i)) begin
                case (reg_sel)
                    C_REG_VALUE:    data_out = w_count_flat[i*BITS +: BITS];
                    C_REG_CTRL:     data_out = {{(BITS-2){1'b0}}, w_running[i], w_periodic[i]};
                    C_REG_PRESCALE: data_out = w_prescale_rd;
                    default:        data_out = '0;
                endcase
            end
        end
    end

    assign irq_any = |interrupt;

endmodule
`default_nettype wire
